// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and FSM state encoding.
// UART_RX_PARITY_EN adds the PARITY state, widening the encoding to 3 bits.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, Mealy rx_done_tick at the stop sample.
// Define UART_RX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int unsigned SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            rx_s;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (rx),
    .q_o  (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    rx_done_tick = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            par_d   = rx_s ^ (^b_q);
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            rx_done_tick = 1'b1;
            state_d      = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout      = b_q;
  assign frame_err = rx_done_tick & ~rx_s;
`ifdef UART_RX_PARITY_EN
  assign parity_err = rx_done_tick & par_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, hand-written corner sequences, random frames
// checked against a frame-level reference model. Honours UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int unsigned DBIT     = 8;
  localparam int unsigned SB_TICK  = 16;
  localparam int unsigned TPT      = 4;            // clk per s_tick
  localparam int unsigned BIT_CLK  = 16 * TPT;
  // A low stop bit is released a little after its sample point so the receiver's
  // break re-start resolves as a false start before the next frame.
  localparam int unsigned STOP_LOW = SB_TICK * TPT / 2 + 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int unsigned LATENCY = 8 + 16 * DBIT + SB_TICK + (PAR_EN ? 16 : 0);

  logic            clk = 1'b0;
  logic            reset;
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            parity_err;
  logic [1:0]      tick_cnt = '0;

  always #5 clk = ~clk;
  always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
  assign s_tick = (tick_cnt == 2'd3);

  uart_rx #(
    .DBIT   (DBIT),
    .SB_TICK(SB_TICK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .s_tick      (s_tick),
    .dout        (dout),
    .rx_done_tick(rx_done_tick),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  typedef struct {
    logic [7:0]  d;
    logic        fe;
    logic        pe;
    int unsigned lat;
  } ev_t;

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic        stop;
    logic        par;
    int unsigned idle;
    logic [7:0]  exp_d;
    logic        exp_fe;
    logic        exp_pe;
  } vec_t;

  ev_t         obs[$];
  int unsigned ticks_since_start = 0;
  int unsigned stray = 0;
  int          checks = 0;
  int          errors = 0;

  always @(negedge clk) begin
    if (s_tick) ticks_since_start = ticks_since_start + 1;
    if (rx_done_tick) obs.push_back('{dout, frame_err, parity_err, ticks_since_start});
    else if (frame_err || parity_err) stray = stray + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t model(input logic [7:0] data, input logic stop, input logic par);
    ev_t e;
    e.d   = data;
    e.fe  = ~stop;
    e.pe  = PAR_EN ? (par ^ (^data)) : 1'b0;
    e.lat = LATENCY;
    return e;
  endfunction

  task automatic align();
    @(negedge clk);
    while (!s_tick) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int unsigned n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par,
                            input int unsigned idle_bits);
    ticks_since_start = 0;
    hold(1'b0, BIT_CLK);
    for (int unsigned i = 0; i < DBIT; i++) hold(data[i], BIT_CLK);
    if (PAR_EN) hold(par, BIT_CLK);
    if (stop) begin
      hold(1'b1, SB_TICK * TPT);
    end else begin
      hold(1'b0, STOP_LOW);
      hold(1'b1, SB_TICK * TPT - STOP_LOW);
    end
    for (int unsigned i = 0; i < idle_bits; i++) hold(1'b1, BIT_CLK);
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic fe,
                             input logic pe);
    chk({name, " done count"}, 64'(obs.size()), 64'd1);
    if (obs.size() > 0) begin
      chk({name, " dout"}, 64'(obs[0].d), 64'(d));
      chk({name, " frame_err"}, 64'(obs[0].fe), 64'(fe));
      chk({name, " parity_err"}, 64'(obs[0].pe), 64'(pe));
      chk({name, " latency ticks"}, 64'(obs[0].lat), 64'(LATENCY));
    end
    obs.delete();
  endtask

  task automatic check_none(input string name);
    chk({name, " done count"}, 64'(obs.size()), 64'd0);
    obs.delete();
  endtask

  vec_t       tbl[7];
  ev_t        e;
  logic [7:0] ab;
  logic [7:0] rd;
  logic       rs, rp;
  int unsigned ri;

  initial begin
    tbl[0] = '{"a5 8n1",   8'hA5, 1'b1, 1'b0, 2, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{"3c badstop", 8'h3C, 1'b0, 1'b0, 1, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{"11 after fe", 8'h11, 1'b1, 1'b0, 1, 8'h11, 1'b0, 1'b0};
    tbl[3] = '{"b2b 00",    8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{"b2b ff",    8'hFF, 1'b1, 1'b0, 2, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{"07 par1",   8'h07, 1'b1, 1'b1, 1, 8'h07, 1'b0, 1'b0};
    tbl[6] = '{"07 par0",   8'h07, 1'b1, 1'b0, 1, 8'h07, 1'b0, PAR_EN};

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dout", 64'(dout), 64'd0);
    chk("reset rx_done_tick", 64'(rx_done_tick), 64'd0);
    chk("reset frame_err", 64'(frame_err), 64'd0);
    chk("reset parity_err", 64'(parity_err), 64'd0);
    reset = 1'b0;
    align();
    hold(1'b1, BIT_CLK);

    for (int unsigned i = 0; i < 7; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].par, tbl[i].idle);
      check_frame(tbl[i].name, tbl[i].exp_d, tbl[i].exp_fe, tbl[i].exp_pe);
    end

    // Glitch shorter than half a bit: rejected, dout keeps the last frame.
    hold(1'b0, 3 * TPT);
    hold(1'b1, 3 * BIT_CLK);
    check_none("glitch");
    chk("glitch dout held", 64'(dout), 64'h07);
    send_frame(8'h5A, 1'b1, 1'b0, 1);
    check_frame("after glitch 5a", 8'h5A, 1'b0, 1'b0);

    // Reset in the middle of the 5th data bit of 0x55.
    ab = 8'h55;
    ticks_since_start = 0;
    hold(1'b0, BIT_CLK);
    for (int unsigned i = 0; i < 4; i++) hold(ab[i], BIT_CLK);
    hold(ab[4], BIT_CLK / 2);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort dout cleared", 64'(dout), 64'd0);
    chk("abort rx_done_tick", 64'(rx_done_tick), 64'd0);
    reset = 1'b0;
    hold(1'b1, 2 * BIT_CLK);
    check_none("aborted 55");
    align();
    send_frame(8'h81, 1'b1, 1'b0, 1);
    check_frame("after abort 81", 8'h81, 1'b0, 1'b0);

    for (int unsigned r = 0; r < 24; r++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom_range(0, 1));
      ri = $urandom_range(0, 2);
      e  = model(rd, rs, rp);
      send_frame(rd, rs, rp, ri);
      check_frame($sformatf("rand%0d", r), e.d, e.fe, e.pe);
    end

    chk("err flags outside done", 64'(stray), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
